// File: rtl/h264_cavlc_pkg.sv
// Shared CAVLC residual types: block kinds, scan tables and store metadata.
package h264_cavlc_pkg;

  localparam int unsigned COEFF_W   = 16;
  localparam int unsigned NUM_COEFF = 16;
  localparam int unsigned BLK_IDX_W = 5;

  typedef enum logic [1:0] {
    LUMA16 = 2'd0,
    AC15   = 2'd1,
    CDC    = 2'd2
  } blk_type_t;

  // Scan position k -> raster position y*4+x
  localparam logic [3:0] ZIGZAG_4x4 [NUM_COEFF] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  localparam logic [3:0] FIELD_4x4 [NUM_COEFF] = '{
    4'd0, 4'd4, 4'd1, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13,
    4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
  };

  typedef struct packed {
    logic [1:0]           blk_type;
    logic [BLK_IDX_W-1:0] blk_idx;
    logic [NUM_COEFF-1:0] nz_mask;
  } blk_meta_t;

endpackage

// File: rtl/cavlc_scan_map.sv
// Inverse scan of one block of scan-ordered levels to raster order, plus nonzero mask.
// CAVLC_FIELD_SCAN_EN adds the field-scan table selected by the field input.
module cavlc_scan_map
  import h264_cavlc_pkg::*;
#(
  parameter int unsigned COEFF_W = h264_cavlc_pkg::COEFF_W
) (
  input  logic [NUM_COEFF*COEFF_W-1:0] in_coeff,
  input  logic [1:0]                   blk_type,
`ifdef CAVLC_FIELD_SCAN_EN
  input  logic                         field,
`endif
  output logic [NUM_COEFF*COEFF_W-1:0] raster_coeff_c,
  output logic [NUM_COEFF-1:0]         nz_mask_c
);

  function automatic logic [3:0] raster_pos(input logic [3:0] k);
`ifdef CAVLC_FIELD_SCAN_EN
    return field ? FIELD_4x4[k] : ZIGZAG_4x4[k];
`else
    return ZIGZAG_4x4[k];
`endif
  endfunction

  always_comb begin
    raster_coeff_c = '0;
    nz_mask_c      = '0;
    case (blk_type_t'(blk_type))
      CDC: begin
        for (int i = 0; i < 4; i++)
          raster_coeff_c[i*COEFF_W +: COEFF_W] = in_coeff[i*COEFF_W +: COEFF_W];
      end
      // AC-only blocks start at scan position 1; raster 0 is left for the DC
      AC15: begin
        for (int i = 0; i < 15; i++)
          raster_coeff_c[32'(raster_pos(4'(i + 1)))*COEFF_W +: COEFF_W] =
            in_coeff[i*COEFF_W +: COEFF_W];
      end
      default: begin
        for (int i = 0; i < 16; i++)
          raster_coeff_c[32'(raster_pos(4'(i)))*COEFF_W +: COEFF_W] =
            in_coeff[i*COEFF_W +: COEFF_W];
      end
    endcase
    for (int r = 0; r < 16; r++)
      nz_mask_c[r] = |raster_coeff_c[r*COEFF_W +: COEFF_W];
  end

endmodule

// File: rtl/cavlc_coeff_reorder.sv
// Two-entry ping-pong store of inverse-scanned CAVLC blocks with valid/ready on both sides.
// CAVLC_FIELD_SCAN_EN adds the in_field port and field-scan support.
module cavlc_coeff_reorder
  import h264_cavlc_pkg::*;
#(
  parameter int unsigned COEFF_W = h264_cavlc_pkg::COEFF_W,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_COEFF*COEFF_W-1:0] in_coeff,
  input  logic [1:0]                   in_blk_type,
  input  logic [BLK_IDX_W-1:0]         in_blk_idx,
`ifdef CAVLC_FIELD_SCAN_EN
  input  logic                         in_field,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_COEFF*COEFF_W-1:0] out_coeff,
  output logic [1:0]                   out_blk_type,
  output logic [BLK_IDX_W-1:0]         out_blk_idx,
  output logic [NUM_COEFF-1:0]         out_nz_mask,
  output logic                         overflow
);

  localparam int unsigned BLK_W = NUM_COEFF * COEFF_W;

  logic [BLK_W-1:0]     map_coeff_c;
  logic [NUM_COEFF-1:0] map_nz_c;

  cavlc_scan_map #(.COEFF_W(COEFF_W)) u_scan_map (
    .in_coeff       (in_coeff),
    .blk_type       (in_blk_type),
`ifdef CAVLC_FIELD_SCAN_EN
    .field          (in_field),
`endif
    .raster_coeff_c (map_coeff_c),
    .nz_mask_c      (map_nz_c)
  );

  logic [BLK_W-1:0] mem_coeff [2];
  blk_meta_t        mem_meta  [2];
  logic [1:0]       cnt, cnt_next;
  logic             wp, rp, rp_next;
  logic             push, pop;
  blk_meta_t        new_meta;
  logic [BLK_W-1:0] head_coeff;
  blk_meta_t        head_meta;

  // Next-state of the store and the entry that will sit at the head after this edge
  always_comb begin
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    cnt_next   = cnt;
    rp_next    = rp ^ pop;
    new_meta   = '{blk_type: in_blk_type, blk_idx: in_blk_idx, nz_mask: map_nz_c};
    head_coeff = mem_coeff[rp_next];
    head_meta  = mem_meta[rp_next];
    case ({push, pop})
      2'b10:   cnt_next = cnt + 2'd1;
      2'b01:   cnt_next = cnt - 2'd1;
      default: cnt_next = cnt;
    endcase
    // A block written into the head slot this cycle bypasses the store
    if (push && (wp == rp_next)) begin
      head_coeff = map_coeff_c;
      head_meta  = new_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 2'd0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
      out_coeff    <= '0;
      out_blk_type <= '0;
      out_blk_idx  <= '0;
      out_nz_mask  <= '0;
    end else begin
      cnt       <= cnt_next;
      wp        <= wp ^ push;
      rp        <= rp_next;
      in_ready  <= (cnt_next != 2'(DEPTH));
      out_valid <= (cnt_next != 2'd0);
      overflow  <= overflow | (in_valid & ~in_ready);
      if (cnt_next != 2'd0) begin
        out_coeff    <= head_coeff;
        out_blk_type <= head_meta.blk_type;
        out_blk_idx  <= head_meta.blk_idx;
        out_nz_mask  <= head_meta.nz_mask;
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_coeff[wp] <= map_coeff_c;
      mem_meta[wp]  <= new_meta;
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_reorder.sv
// Self-checking bench for cavlc_coeff_reorder: queue-based reference model plus directed literals.
module tb_cavlc_coeff_reorder;

  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  localparam int FD [16] = '{0, 4, 1, 8, 12, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_coeff = '0;
  logic [1:0]   in_blk_type = 2'd0;
  logic [4:0]   in_blk_idx = 5'd0;
`ifdef CAVLC_FIELD_SCAN_EN
  logic         in_field = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_coeff;
  logic [1:0]   out_blk_type;
  logic [4:0]   out_blk_idx;
  logic [15:0]  out_nz_mask;
  logic         overflow;

  always #5 clk = ~clk;

  cavlc_coeff_reorder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_coeff     (in_coeff),
    .in_blk_type  (in_blk_type),
    .in_blk_idx   (in_blk_idx),
`ifdef CAVLC_FIELD_SCAN_EN
    .in_field     (in_field),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_coeff    (out_coeff),
    .out_blk_type (out_blk_type),
    .out_blk_idx  (out_blk_idx),
    .out_nz_mask  (out_nz_mask),
    .overflow     (overflow)
  );

  typedef struct {
    logic [255:0] coeff;
    logic [1:0]   typ;
    logic [4:0]   idx;
    logic [15:0]  nz;
  } blk_t;

  blk_t q[$];
  bit   m_ovf = 1'b0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference inverse scan: place level values by scan position using the tables
  function automatic logic [255:0] map_ref(input logic [255:0] c, input int typ, input bit fld);
    logic [255:0] r;
    logic [15:0]  scan [16];
    r = '0;
    if (typ == 2) begin
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = c[i*16 +: 16];
      return r;
    end
    for (int k = 0; k < 16; k++) begin
      if (typ == 1) scan[k] = (k == 0) ? 16'd0 : c[(k-1)*16 +: 16];
      else          scan[k] = c[k*16 +: 16];
    end
    for (int k = 0; k < 16; k++) r[(fld ? FD[k] : ZZ[k])*16 +: 16] = scan[k];
    return r;
  endfunction

  function automatic logic [15:0] nz_ref(input logic [255:0] r);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (r[i*16 +: 16] != 16'd0);
    return m;
  endfunction

  function automatic logic [255:0] pack16(input int v [16]);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(v[i]);
    return r;
  endfunction

  // Model: FIFO of at most two blocks, updated on every active edge
  always @(posedge clk) begin
    bit   pu, po, f;
    blk_t e;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pu = in_valid && (q.size() != 2);
      po = (q.size() != 0) && out_ready;
      if (in_valid && q.size() == 2) m_ovf = 1'b1;
      f = 1'b0;
`ifdef CAVLC_FIELD_SCAN_EN
      f = in_field;
`endif
      e.coeff = map_ref(in_coeff, int'(in_blk_type), f);
      e.typ   = in_blk_type;
      e.idx   = in_blk_idx;
      e.nz    = nz_ref(e.coeff);
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 256'(in_ready), 256'(q.size() != 2));
      check("out_valid", 256'(out_valid), 256'(q.size() != 0));
      check("overflow", 256'(overflow), 256'(m_ovf));
      if (q.size() != 0) begin
        check("out_coeff", out_coeff, q[0].coeff);
        check("out_blk_type", 256'(out_blk_type), 256'(q[0].typ));
        check("out_blk_idx", 256'(out_blk_idx), 256'(q[0].idx));
        check("out_nz_mask", 256'(out_nz_mask), 256'(q[0].nz));
      end
    end
  end

  task automatic set_blk(input bit v, input logic [255:0] c, input logic [1:0] t, input logic [4:0] idx);
    in_valid    = v;
    in_coeff    = c;
    in_blk_type = t;
    in_blk_idx  = idx;
  endtask

  function automatic logic [255:0] rand_coeff();
    logic [255:0] c;
    for (int i = 0; i < 16; i++) c[i*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
    return c;
  endfunction

  initial begin
    int           lit [16];
    logic [255:0] c, b1;

    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_overflow", 256'(overflow), 256'd0);
    check("rst_out_coeff", out_coeff, 256'd0);
    check("rst_nz_mask", 256'(out_nz_mask), 256'd0);

    // LUMA16, level_i = i+1, frame zigzag
    for (int i = 0; i < 16; i++) c[i*16 +: 16] = 16'(i + 1);
    set_blk(1'b1, c, 2'd0, 5'd3);
    @(negedge clk);
    set_blk(1'b0, '0, 2'd0, 5'd0);
    lit = '{1, 2, 6, 7, 3, 5, 8, 13, 4, 9, 12, 14, 10, 11, 15, 16};
    check("luma_raster", out_coeff, pack16(lit));
    check("luma_mask", 256'(out_nz_mask), 256'h0000_ffff);
    check("luma_valid", 256'(out_valid), 256'd1);

    // AC15, level_0 = 5
    c = '0; c[15:0] = 16'd5;
    set_blk(1'b1, c, 2'd1, 5'd4);
    @(negedge clk);
    set_blk(1'b0, '0, 2'd0, 5'd0);
    lit = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check("ac15_raster", out_coeff, pack16(lit));
    check("ac15_mask", 256'(out_nz_mask), 256'h0002);

    // CDC, levels 3,-1,0,2
    c = '0; c[15:0] = 16'd3; c[31:16] = 16'hffff; c[63:48] = 16'd2;
    set_blk(1'b1, c, 2'd2, 5'd16);
    @(negedge clk);
    set_blk(1'b0, '0, 2'd0, 5'd0);
    lit = '{3, 65535, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check("cdc_raster", out_coeff, pack16(lit));
    check("cdc_mask", 256'(out_nz_mask), 256'h000b);
    check("cdc_type", 256'(out_blk_type), 256'd2);
    repeat (2) @(negedge clk);

    // Stall: three back-to-back pushes, third dropped
    out_ready = 1'b0;
    b1 = rand_coeff();
    set_blk(1'b1, b1, 2'd0, 5'd1);
    @(negedge clk);
    set_blk(1'b1, rand_coeff(), 2'd1, 5'd2);
    @(negedge clk);
    check("full_in_ready", 256'(in_ready), 256'd0);
    set_blk(1'b1, rand_coeff(), 2'd0, 5'd3);
    @(negedge clk);
    set_blk(1'b0, '0, 2'd0, 5'd0);
    check("ovf_set", 256'(overflow), 256'd1);
    repeat (3) @(negedge clk);
    check("stall_idx", 256'(out_blk_idx), 256'd1);
    check("stall_coeff", out_coeff, map_ref(b1, 0, 1'b0));
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_idx2", 256'(out_blk_idx), 256'd2);
    @(negedge clk);
    check("drain_empty", 256'(out_valid), 256'd0);

    // Continuous streaming, 20 blocks
    for (int i = 0; i < 20; i++) begin
      set_blk(1'b1, rand_coeff(), 2'($urandom_range(0, 3)), 5'(i));
      @(negedge clk);
      check("stream_valid", 256'(out_valid), 256'd1);
      check("stream_ready", 256'(in_ready), 256'd1);
      check("stream_idx", 256'(out_blk_idx), 256'(i));
    end
    set_blk(1'b0, '0, 2'd0, 5'd0);
    @(negedge clk);

`ifdef CAVLC_FIELD_SCAN_EN
    // Field scan: LUMA16 level_2 = 7 lands at raster 1
    c = '0; c[47:32] = 16'd7;
    in_field = 1'b1;
    set_blk(1'b1, c, 2'd0, 5'd9);
    @(negedge clk);
    set_blk(1'b0, '0, 2'd0, 5'd0);
    in_field = 1'b0;
    lit = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check("field_raster", out_coeff, pack16(lit));
    check("field_mask", 256'(out_nz_mask), 256'h0002);
    @(negedge clk);
`endif

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      set_blk($urandom_range(0, 3) != 0, rand_coeff(), 2'($urandom_range(0, 3)), 5'($urandom));
`ifdef CAVLC_FIELD_SCAN_EN
      in_field = 1'($urandom);
`endif
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end

    // Reset in the middle of a stall with overflow set
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_blk(1'b1, rand_coeff(), 2'd0, 5'(i));
      @(negedge clk);
    end
    set_blk(1'b0, '0, 2'd0, 5'd0);
    check("pre_rst_ovf", 256'(overflow), 256'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 256'(out_valid), 256'd0);
    check("mid_rst_ready", 256'(in_ready), 256'd1);
    check("mid_rst_ovf", 256'(overflow), 256'd0);
    check("mid_rst_coeff", out_coeff, 256'd0);
    check("mid_rst_idx", 256'(out_blk_idx), 256'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
